llc_mem_bridge: RTL and testbench

LLC_MEM_BRIDGE -- requirements
Module: llc_mem_bridge

---
 rtl/llc_mem_bridge_pkg.sv | 66 ++++++
 rtl/llc_mem_line_buf.sv | 39 +++
 rtl/llc_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_llc_mem_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_mem_bridge_pkg.sv
// Shared types and constants for the LLC <-> memory-bus bridge.
// Supplies default values for WORDS_PER_LINE, BITS_PER_WORD, ADDR_BITS and
// BITS_PER_LINE when the build does not define them, so that every file
// importing this package sees one consistent geometry.

`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif

`ifndef BITS_PER_WORD
`define BITS_PER_WORD 32
`endif

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif

`ifndef BITS_PER_LINE
`define BITS_PER_LINE (`WORDS_PER_LINE * `BITS_PER_WORD)
`endif

package llc_mem_bridge_pkg;

  localparam int ADDR_W      = `ADDR_BITS;
  localparam int WORD_W      = `BITS_PER_WORD;
  localparam int LINE_WORDS  = `WORDS_PER_LINE;
  localparam int LINE_W      = `BITS_PER_LINE;
  // Byte distance between consecutive beats of one line.
  localparam int WORD_OFFSET = WORD_W / 8;

  typedef struct packed {
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        hprot;
    logic [ADDR_W-1:0] addr;    // line aligned
    logic [LINE_W-1:0] line;
  } llc_mem_req_t;

  typedef struct packed {
    logic [LINE_W-1:0] line;
  } llc_mem_rsp_t;

  typedef struct packed {
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        hprot;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              last;
  } mem_beat_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BEAT = 3'd1,
    RD_ADDR = 3'd2,
    RD_BEAT = 3'd3,
    RSP_OUT = 3'd4
  } bridge_state_e;

  // Bus address of beat 'idx' within the line starting at 'base'.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input int unsigned       idx);
    return base + ADDR_W'(idx * WORD_OFFSET);
  endfunction

endpackage

// File: rtl/llc_mem_line_buf.sv
// Word-indexed line register used to assemble read data.
// A write stores one word at i_wr_idx; with i_zero_above set in the same cycle
// every word above that index is cleared, so a burst that ends early leaves
// zeros in the words the memory never returned.

module llc_mem_line_buf #(
  parameter  int WORDS     = 4,
  parameter  int WORD_BITS = 32,
  localparam int IDX_W     = $clog2(WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [IDX_W-1:0]           i_wr_idx,
  input  logic [WORD_BITS-1:0]       i_wr_data,
  input  logic                       i_zero_above,
  output logic [WORDS*WORD_BITS-1:0] o_line
);

  logic [WORDS-1:0][WORD_BITS-1:0] r_words;

  // Store the incoming word and optionally zero-fill the words above it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_words <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < WORDS; i++) begin
        if (i == 32'(i_wr_idx)) begin
          r_words[i] <= i_wr_data;
        end else if (i_zero_above && (i > 32'(i_wr_idx))) begin
          r_words[i] <= '0;
        end
      end
    end
  end

  assign o_line = r_words;

endmodule

// File: rtl/llc_mem_bridge.sv
// LLC <-> memory-bus bridge.
// Splits an LLC line write into WORDS_PER_LINE bus beats, and turns an LLC
// line read into one address beat followed by a burst of read-data beats that
// is collected into a line and handed back to the LLC.
// Optional statistics counters are built when LLC_MEM_BRIDGE_STATS_EN is
// defined; without it the stat ports and counters do not exist.
// The package geometry (WORD_W, LINE_W) must match WORD_BITS and
// WORDS_PER_LINE*WORD_BITS, as the port structs are sized from the package.
//
// Handshakes: every valid/ready pair transfers exactly on a clock edge where
// both are high. A source holding valid keeps its payload unchanged until that
// edge, and valid is never withdrawn before the transfer completes.

`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif

`ifndef BITS_PER_WORD
`define BITS_PER_WORD 32
`endif

module llc_mem_bridge
  import llc_mem_bridge_pkg::*;
#(
  parameter int WORDS_PER_LINE = `WORDS_PER_LINE,
  parameter int WORD_BITS      = `BITS_PER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 llc_mem_req_valid,
  output logic                 llc_mem_req_ready,
  input  llc_mem_req_t         llc_mem_req,
  output logic                 llc_mem_rsp_valid,
  input  logic                 llc_mem_rsp_ready,
  output llc_mem_rsp_t         llc_mem_rsp,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output mem_beat_t            bus_req_beat,
  input  logic                 bus_rsp_valid,
  output logic                 bus_rsp_ready,
  input  logic [WORD_BITS-1:0] bus_rsp_data,
  input  logic                 bus_rsp_last,
  output bridge_state_e        dbg_state
`ifdef LLC_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]          stat_wr_lines,
  output logic [31:0]          stat_rd_lines,
  output logic [15:0]          stat_short_bursts
`endif
);

  localparam int              CNT_W    = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

  bridge_state_e                         r_state;
  bridge_state_e                         w_next_state;
  logic [CNT_W-1:0]                      r_cnt;
  llc_mem_req_t                          r_req;
  logic                                  r_req_ready;
  logic                                  r_bus_valid;
  mem_beat_t                             r_bus_beat;
  logic [WORDS_PER_LINE*WORD_BITS-1:0]   w_line;

  logic w_req_fire;
  logic w_bus_fire;
  logic w_in_rd_beat;
  logic w_rsp_in_fire;
  logic w_cnt_last;
  logic w_rd_done;
  logic w_wr_done;

  // Write beat 'idx' of a line: word 0 sits in the line LSBs.
  function automatic mem_beat_t wr_beat(input llc_mem_req_t     req,
                                        input logic [CNT_W-1:0] idx);
    mem_beat_t b;
    b        = '0;
    b.hwrite = req.hwrite;
    b.hsize  = req.hsize;
    b.hprot  = req.hprot;
    b.addr   = beat_addr(req.addr, 32'(idx));
    b.wdata  = req.line[32'(idx)*WORD_BITS +: WORD_BITS];
    b.last   = (idx == CNT_LAST);
    return b;
  endfunction

  // Single address beat that opens a read burst.
  function automatic mem_beat_t rd_addr_beat(input llc_mem_req_t req);
    mem_beat_t b;
    b        = '0;
    b.hwrite = 1'b0;
    b.hsize  = req.hsize;
    b.hprot  = req.hprot;
    b.addr   = req.addr;
    b.wdata  = '0;
    b.last   = 1'b1;
    return b;
  endfunction

  assign w_req_fire    = llc_mem_req_valid & r_req_ready;
  assign w_bus_fire    = r_bus_valid & bus_req_ready;
  assign w_in_rd_beat  = (r_state == RD_BEAT);
  assign w_rsp_in_fire = bus_rsp_valid & w_in_rd_beat;
  assign w_cnt_last    = (r_cnt == CNT_LAST);
  // A read burst ends on the memory's last flag or when the line is full.
  assign w_rd_done     = w_rsp_in_fire & (bus_rsp_last | w_cnt_last);
  assign w_wr_done     = (r_state == WR_BEAT) & w_bus_fire & w_cnt_last;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and state-decoded handshake outputs.
  always_comb begin
    w_next_state      = r_state;
    bus_rsp_ready     = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          w_next_state = llc_mem_req.hwrite ? WR_BEAT : RD_ADDR;
        end
      end
      WR_BEAT: begin
        if (w_wr_done) begin
          w_next_state = IDLE;
        end
      end
      RD_ADDR: begin
        if (w_bus_fire) begin
          w_next_state = RD_BEAT;
        end
      end
      RD_BEAT: begin
        bus_rsp_ready = 1'b1;
        if (w_rd_done) begin
          w_next_state = RSP_OUT;
        end
      end
      RSP_OUT: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request capture, beat counter and registered bus-request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_beat  <= '0;
    end else begin
      // Ready is registered so it stays low through reset and rises in the
      // first IDLE cycle afterwards.
      r_req_ready <= (w_next_state == IDLE);
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_req       <= llc_mem_req;
            r_cnt       <= '0;
            r_bus_valid <= 1'b1;
            r_bus_beat  <= llc_mem_req.hwrite ? wr_beat(llc_mem_req, '0)
                                              : rd_addr_beat(llc_mem_req);
          end
        end
        WR_BEAT: begin
          if (w_bus_fire) begin
            if (w_cnt_last) begin
              r_bus_valid <= 1'b0;
              r_bus_beat  <= '0;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_bus_beat <= wr_beat(r_req, r_cnt + 1'b1);
            end
          end
        end
        RD_ADDR: begin
          if (w_bus_fire) begin
            r_bus_valid <= 1'b0;
            r_bus_beat  <= '0;
            r_cnt       <= '0;
          end
        end
        RD_BEAT: begin
          // The counter never wraps inside a burst; it restarts on acceptance.
          if (w_rsp_in_fire && !w_rd_done) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  llc_mem_line_buf #(
    .WORDS     (WORDS_PER_LINE),
    .WORD_BITS (WORD_BITS)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_rsp_in_fire),
    .i_wr_idx     (r_cnt),
    .i_wr_data    (bus_rsp_data),
    .i_zero_above (bus_rsp_last),
    .o_line       (w_line)
  );

  assign llc_mem_req_ready = r_req_ready;
  assign bus_req_valid     = r_bus_valid;
  assign bus_req_beat      = r_bus_beat;
  assign llc_mem_rsp.line  = w_line;
  assign dbg_state         = r_state;

`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic        w_short_burst;
  logic        w_rd_handoff;
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_rd;
  logic [15:0] r_stat_short;

  assign w_short_burst = w_rsp_in_fire & bus_rsp_last & ~w_cnt_last;
  assign w_rd_handoff  = (r_state == RSP_OUT) & llc_mem_rsp_ready;

  // Saturating event counters for completed writes, delivered reads and
  // bursts that the memory ended early.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_wr    <= '0;
      r_stat_rd    <= '0;
      r_stat_short <= '0;
    end else begin
      if (w_wr_done && (r_stat_wr != '1)) begin
        r_stat_wr <= r_stat_wr + 1'b1;
      end
      if (w_rd_handoff && (r_stat_rd != '1)) begin
        r_stat_rd <= r_stat_rd + 1'b1;
      end
      if (w_short_burst && (r_stat_short != '1)) begin
        r_stat_short <= r_stat_short + 1'b1;
      end
    end
  end

  assign stat_wr_lines     = r_stat_wr;
  assign stat_rd_lines     = r_stat_rd;
  assign stat_short_bursts = r_stat_short;
`endif

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Directed testbench for llc_mem_bridge (4 words of 32 bits per line).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_llc_mem_bridge;
  import llc_mem_bridge_pkg::*;

  localparam int WPL = LINE_WORDS;
  localparam int WB  = WORD_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          llc_mem_req_valid;
  logic          llc_mem_req_ready;
  llc_mem_req_t  llc_mem_req;
  logic          llc_mem_rsp_valid;
  logic          llc_mem_rsp_ready;
  llc_mem_rsp_t  llc_mem_rsp;
  logic          bus_req_valid;
  logic          bus_req_ready;
  mem_beat_t     bus_req_beat;
  logic          bus_rsp_valid;
  logic          bus_rsp_ready;
  logic [WB-1:0] bus_rsp_data;
  logic          bus_rsp_last;
  bridge_state_e dbg_state;
`ifdef LLC_MEM_BRIDGE_STATS_EN
  logic [31:0]   stat_wr_lines;
  logic [31:0]   stat_rd_lines;
  logic [15:0]   stat_short_bursts;
`endif

  int checks = 0;
  int errors = 0;

  llc_mem_bridge #(
    .WORDS_PER_LINE (WPL),
    .WORD_BITS      (WB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .llc_mem_req_valid (llc_mem_req_valid),
    .llc_mem_req_ready (llc_mem_req_ready),
    .llc_mem_req       (llc_mem_req),
    .llc_mem_rsp_valid (llc_mem_rsp_valid),
    .llc_mem_rsp_ready (llc_mem_rsp_ready),
    .llc_mem_rsp       (llc_mem_rsp),
    .bus_req_valid     (bus_req_valid),
    .bus_req_ready     (bus_req_ready),
    .bus_req_beat      (bus_req_beat),
    .bus_rsp_valid     (bus_rsp_valid),
    .bus_rsp_ready     (bus_rsp_ready),
    .bus_rsp_data      (bus_rsp_data),
    .bus_rsp_last      (bus_rsp_last),
    .dbg_state         (dbg_state)
`ifdef LLC_MEM_BRIDGE_STATS_EN
    ,
    .stat_wr_lines     (stat_wr_lines),
    .stat_rd_lines     (stat_rd_lines),
    .stat_short_bursts (stat_short_bursts)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present one LLC request and return on the falling edge after it
  // has been accepted.
  task automatic send_req(input logic hw, input logic [2:0] hs, input logic [1:0] hp,
                          input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] ln);
    int k;
    @(negedge clk);
    llc_mem_req_valid  = 1'b1;
    llc_mem_req.hwrite = hw;
    llc_mem_req.hsize  = hs;
    llc_mem_req.hprot  = hp;
    llc_mem_req.addr   = a;
    llc_mem_req.line   = ln;
    k = 0;
    while (!llc_mem_req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (llc_mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept: llc_mem_req_ready=%0b, required 1 within 20 cycles", llc_mem_req_ready);
    end
    @(negedge clk);
    llc_mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    llc_mem_req_valid = 1'b0;
    llc_mem_req = '0;
    llc_mem_rsp_ready = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data = '0;
    bus_rsp_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (llc_mem_req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_req_ready: got %0b, required 0", llc_mem_req_ready);
    end
    checks++;
    if ({llc_mem_rsp_valid, bus_req_valid, bus_rsp_ready} !== 3'b000) begin
      errors++; $display("FAIL rst_valids: rsp_valid/bus_req_valid/bus_rsp_ready=%b, required 000",
                         {llc_mem_rsp_valid, bus_req_valid, bus_rsp_ready});
    end
    checks++;
    if (bus_req_beat !== '0) begin
      errors++; $display("FAIL rst_beat: got %h, required 0", bus_req_beat);
    end
    checks++;
    if (llc_mem_rsp.line !== '0) begin
      errors++; $display("FAIL rst_line: got %h, required 0", llc_mem_rsp.line);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_state: got %0d, required IDLE", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (llc_mem_req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_first_idle_ready: got %0b, required 1", llc_mem_req_ready);
    end
  endtask

  task automatic test_write();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [WB-1:0]     exp_data [4];
    int n;
    bit rsp_seen;
    exp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_data = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
    bus_req_ready = 1'b1;
    send_req(1'b1, 3'b010, 2'b01, 32'h1000, {32'hDD, 32'hCC, 32'hBB, 32'hAA});
    checks++;
    if (bus_req_valid !== 1'b1) begin
      errors++; $display("FAIL wr_latency: bus_req_valid=%0b one cycle after accept, required 1", bus_req_valid);
    end
    n = 0;
    rsp_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (llc_mem_rsp_valid === 1'b1) rsp_seen = 1'b1;
      if (bus_req_valid === 1'b1) begin
        if (n < 4) begin
          checks++;
          if (bus_req_beat.addr !== exp_addr[n] || bus_req_beat.wdata !== exp_data[n] ||
              bus_req_beat.last !== (n == 3) || bus_req_beat.hwrite !== 1'b1 ||
              bus_req_beat.hsize !== 3'b010 || bus_req_beat.hprot !== 2'b01) begin
            errors++;
            $display("FAIL wr_beat%0d: addr=%h wdata=%h last=%0b hw=%0b hs=%0d hp=%0d, required addr=%h wdata=%h last=%0b hw=1 hs=2 hp=1",
                     n, bus_req_beat.addr, bus_req_beat.wdata, bus_req_beat.last, bus_req_beat.hwrite,
                     bus_req_beat.hsize, bus_req_beat.hprot, exp_addr[n], exp_data[n], (n == 3));
          end
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL wr_beat_count: got %0d, required 4", n);
    end
    checks++;
    if (rsp_seen !== 1'b0) begin
      errors++; $display("FAIL wr_no_llc_rsp: llc_mem_rsp_valid seen=%0b, required 0", rsp_seen);
    end
    checks++;
    if (dbg_state !== IDLE || llc_mem_req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_end_idle: state=%0d ready=%0b, required IDLE and 1", dbg_state, llc_mem_req_ready);
    end
  endtask

  task automatic test_write_stall();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [WB-1:0]     exp_data [4];
    bit pat [4];
    int n;
    exp_addr = '{32'h1400, 32'h1404, 32'h1408, 32'h140C};
    exp_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus_req_ready = 1'b0;
    send_req(1'b1, 3'b011, 2'b10, 32'h1400,
             {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    n = 0;
    for (int c = 0; c < 40; c++) begin
      bus_req_ready = pat[c % 4];
      if (bus_req_valid === 1'b1) begin
        if (n < 4) begin
          checks++;
          if (bus_req_beat.addr !== exp_addr[n] || bus_req_beat.wdata !== exp_data[n] ||
              bus_req_beat.last !== (n == 3) || bus_req_beat.hsize !== 3'b011 ||
              bus_req_beat.hprot !== 2'b10) begin
            errors++;
            $display("FAIL stall_beat%0d cycle%0d: addr=%h wdata=%h last=%0b, required addr=%h wdata=%h last=%0b",
                     n, c, bus_req_beat.addr, bus_req_beat.wdata, bus_req_beat.last,
                     exp_addr[n], exp_data[n], (n == 3));
          end
        end
        if (bus_req_ready) n++;
      end
      @(negedge clk);
    end
    bus_req_ready = 1'b1;
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL stall_beat_count: got %0d, required 4", n);
    end
    checks++;
    if (bus_req_valid !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL stall_end: valid=%0b state=%0d, required 0 and IDLE", bus_req_valid, dbg_state);
    end
  endtask

  task automatic test_read();
    bus_req_ready = 1'b1;
    send_req(1'b0, 3'b011, 2'b10, 32'h2000, {4{32'hFFFF0000}});
    checks++;
    if (bus_req_valid !== 1'b1 || bus_req_beat.addr !== 32'h2000 || bus_req_beat.hwrite !== 1'b0 ||
        bus_req_beat.last !== 1'b1 || bus_req_beat.wdata !== '0 ||
        bus_req_beat.hsize !== 3'b011 || bus_req_beat.hprot !== 2'b10) begin
      errors++;
      $display("FAIL rd_addr_beat: valid=%0b addr=%h hw=%0b last=%0b wdata=%h, required 1 2000 0 1 0",
               bus_req_valid, bus_req_beat.addr, bus_req_beat.hwrite, bus_req_beat.last, bus_req_beat.wdata);
    end
    checks++;
    if (bus_rsp_ready !== 1'b0) begin
      errors++; $display("FAIL rd_addr_rsp_ready: got %0b, required 0", bus_rsp_ready);
    end
    // Stray read data while the address beat is outstanding must be ignored.
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'hDEAD;
    bus_rsp_last  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL rd_single_addr: bus_req_valid=%0b after addr handshake, required 0", bus_req_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus_rsp_ready !== 1'b1) begin
        errors++; $display("FAIL rd_beat_ready%0d: got %0b, required 1", i, bus_rsp_ready);
      end
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = WB'(i + 1);
      bus_rsp_last  = (i == 3);
      @(negedge clk);
    end
    bus_rsp_valid = 1'b0;
    bus_rsp_last  = 1'b0;
    checks++;
    if (llc_mem_rsp_valid !== 1'b1 || llc_mem_rsp.line !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      errors++; $display("FAIL rd_line: valid=%0b line=%h, required 1 and 00000004000000030000000200000001",
                         llc_mem_rsp_valid, llc_mem_rsp.line);
    end
    llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    llc_mem_rsp_ready = 1'b0;
    checks++;
    if (llc_mem_rsp_valid !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL rd_handoff: valid=%0b state=%0d, required 0 and IDLE", llc_mem_rsp_valid, dbg_state);
    end
  endtask

  task automatic test_short_read();
    bus_req_ready = 1'b1;
    send_req(1'b0, 3'b010, 2'b00, 32'h2040, '0);
    @(negedge clk);
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'd7;
    bus_rsp_last  = 1'b0;
    @(negedge clk);
    bus_rsp_data  = 32'd8;
    bus_rsp_last  = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    bus_rsp_last  = 1'b0;
    checks++;
    if (llc_mem_rsp_valid !== 1'b1 || llc_mem_rsp.line !== {32'd0, 32'd0, 32'd8, 32'd7}) begin
      errors++; $display("FAIL short_line: valid=%0b line=%h, required 1 and 00000000000000000000000800000007",
                         llc_mem_rsp_valid, llc_mem_rsp.line);
    end
`ifdef LLC_MEM_BRIDGE_STATS_EN
    checks++;
    if (stat_short_bursts !== 16'd1 || stat_wr_lines !== 32'd2 || stat_rd_lines !== 32'd1) begin
      errors++; $display("FAIL short_stats: short=%0d wr=%0d rd=%0d, required 1 2 1",
                         stat_short_bursts, stat_wr_lines, stat_rd_lines);
    end
`endif
    llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    llc_mem_rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    bus_req_ready = 1'b1;
    send_req(1'b0, 3'b010, 2'b11, 32'h3000, '0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = WB'((i + 1) * 32'h11);
      bus_rsp_last  = (i == 3);
      @(negedge clk);
    end
    bus_rsp_valid = 1'b0;
    bus_rsp_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (llc_mem_rsp_valid !== 1'b1 || llc_mem_req_ready !== 1'b0 ||
          llc_mem_rsp.line !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
        errors++; $display("FAIL bp_hold%0d: valid=%0b req_ready=%0b line=%h, required 1 0 00000044000000330000002200000011",
                           c, llc_mem_rsp_valid, llc_mem_req_ready, llc_mem_rsp.line);
      end
      @(negedge clk);
    end
    llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    llc_mem_rsp_ready = 1'b0;
    checks++;
    if (llc_mem_rsp_valid !== 1'b0 || llc_mem_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%0b req_ready=%0b, required 0 1", llc_mem_rsp_valid, llc_mem_req_ready);
    end
`ifdef LLC_MEM_BRIDGE_STATS_EN
    checks++;
    if (stat_rd_lines !== 32'd3) begin
      errors++; $display("FAIL bp_stat_rd: got %0d, required 3", stat_rd_lines);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [WB-1:0]     exp_data [4];
    int n;
    exp_addr = '{32'h5000, 32'h5004, 32'h5008, 32'h500C};
    exp_data = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    bus_req_ready = 1'b1;
    send_req(1'b1, 3'b010, 2'b01, 32'h1000, {32'h4, 32'h3, 32'h2, 32'h1});
    repeat (2) @(negedge clk);
    checks++;
    if (bus_req_valid !== 1'b1 || bus_req_beat.addr !== 32'h1008) begin
      errors++; $display("FAIL mid_pre_reset: valid=%0b addr=%h, required 1 1008", bus_req_valid, bus_req_beat.addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_req_valid, llc_mem_rsp_valid, bus_rsp_ready, llc_mem_req_ready} !== 4'b0000 ||
        dbg_state !== IDLE || bus_req_beat !== '0) begin
      errors++; $display("FAIL mid_reset: valids=%b state=%0d beat=%h, required 0000 IDLE 0",
                         {bus_req_valid, llc_mem_rsp_valid, bus_rsp_ready, llc_mem_req_ready}, dbg_state, bus_req_beat);
    end
`ifdef LLC_MEM_BRIDGE_STATS_EN
    checks++;
    if (stat_wr_lines !== 32'd0 || stat_rd_lines !== 32'd0 || stat_short_bursts !== 16'd0) begin
      errors++; $display("FAIL mid_stats_clear: wr=%0d rd=%0d short=%0d, required 0 0 0",
                         stat_wr_lines, stat_rd_lines, stat_short_bursts);
    end
`endif
    rst = 1'b1;
    send_req(1'b1, 3'b001, 2'b00, 32'h5000, {32'hD4, 32'hC3, 32'hB2, 32'hA1});
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus_req_valid === 1'b1) begin
        if (n < 4) begin
          checks++;
          if (bus_req_beat.addr !== exp_addr[n] || bus_req_beat.wdata !== exp_data[n] ||
              bus_req_beat.last !== (n == 3) || bus_req_beat.hsize !== 3'b001 || bus_req_beat.hprot !== 2'b00) begin
            errors++;
            $display("FAIL post_rst_beat%0d: addr=%h wdata=%h last=%0b, required addr=%h wdata=%h last=%0b",
                     n, bus_req_beat.addr, bus_req_beat.wdata, bus_req_beat.last, exp_addr[n], exp_data[n], (n == 3));
          end
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL post_rst_count: got %0d, required 4", n);
    end
`ifdef LLC_MEM_BRIDGE_STATS_EN
    checks++;
    if (stat_wr_lines !== 32'd1) begin
      errors++; $display("FAIL post_rst_stat_wr: got %0d, required 1", stat_wr_lines);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_stall();
    test_read();
    test_short_read();
    test_rsp_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
